// File: rtl/bound_flash_param.sv
// bound_flash_param -- parameterised "bound flash" lamp sequencer.
//
// A thermometer-coded lamp bar runs through six phases:
//   UP_A (0->PEAK_A), DN_A (->0), UP_B (->PEAK_B), DN_B (->FLOOR_B),
//   UP_C (->N_LAMP), DN_C (->0), then back to IDLE (or straight to UP_A
//   when flick is held or AUTO_REPEAT is set).
// Level moves one step per prescaler tick (every STEP_DIV cycles).
// In UP_B/UP_C a held flick at a kick level throws the bar back one phase.
// abort sends any active phase straight into DN_C for a graceful run-down.
//
// Ports:
//   clk    in   single clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   flick  in   start / restart / kickback request
//   abort  in   graceful shutdown request
//   lamp   out  [N_LAMP] thermometer code, lamp[i]=1 iff i<level
//   busy   out  1 while phase is not IDLE
//   phase  out  [3] IDLE=0 UP_A=1 DN_A=2 UP_B=3 DN_B=4 UP_C=5 DN_C=6
module bound_flash_param #(
    parameter int N_LAMP      = 16,
    parameter int PEAK_A      = 6,
    parameter int PEAK_B      = 11,
    parameter int FLOOR_B     = 5,
    parameter int KICK_A      = 6,
    parameter int KICK_B      = 11,
    parameter int STEP_DIV    = 1,
    parameter int AUTO_REPEAT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flick,
    input  logic              abort,
    output logic [N_LAMP-1:0] lamp,
    output logic              busy,
    output logic [2:0]        phase
);

    // Elaboration guard: refuse parameter sets the sequence cannot honour.
    if (!(PEAK_A > 0 && PEAK_A <= N_LAMP &&
          FLOOR_B >= 0 && FLOOR_B < PEAK_B && PEAK_B <= N_LAMP &&
          KICK_A > 0 && KICK_A <= N_LAMP &&
          KICK_B > 0 && KICK_B <= N_LAMP &&
          STEP_DIV >= 1)) begin : g_bad_params
        $fatal(1, "bound_flash_param: illegal parameter set");
    end

    localparam int LW = $clog2(N_LAMP + 1);
    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    localparam logic [LW-1:0] PA_L   = LW'(PEAK_A);
    localparam logic [LW-1:0] PB_L   = LW'(PEAK_B);
    localparam logic [LW-1:0] FB_L   = LW'(FLOOR_B);
    localparam logic [LW-1:0] FULL_L = LW'(N_LAMP);
    localparam logic [LW-1:0] KA_L   = LW'(KICK_A);
    localparam logic [LW-1:0] KB_L   = LW'(KICK_B);
    localparam logic [PW-1:0] PMAX   = PW'(STEP_DIV - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        UP_A = 3'd1,
        DN_A = 3'd2,
        UP_B = 3'd3,
        DN_B = 3'd4,
        UP_C = 3'd5,
        DN_C = 3'd6
    } phase_e;

    phase_e          phase_q, phase_d;
    logic [LW-1:0]   level_q, level_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [LW-1:0]   target;
    logic [LW-1:0]   step_lvl;
    logic            tick;
    logic            kick_lvl;
    logic            up_kickable;

    assign tick = (phase_q != IDLE) && (presc_q == PMAX);

    always_comb begin
        target = '0;
        case (phase_q)
            UP_A:    target = PA_L;
            UP_B:    target = PB_L;
            DN_B:    target = FB_L;
            UP_C:    target = FULL_L;
            default: target = '0;
        endcase
    end

    // One step toward the target; saturates on the target so it never wraps.
    always_comb begin
        step_lvl = level_q;
        if (level_q < target)
            step_lvl = level_q + 1'b1;
        else if (level_q > target)
            step_lvl = level_q - 1'b1;
    end

    assign kick_lvl    = (step_lvl == KA_L) || (step_lvl == KB_L);
    assign up_kickable = (phase_q == UP_B) || (phase_q == UP_C);

    always_comb begin
        phase_d = phase_q;
        level_d = level_q;
        presc_d = presc_q;
        if (phase_q == IDLE) begin
            if (flick && !abort) begin
                phase_d = UP_A;
                level_d = '0;
                presc_d = '0;
            end
        end else if (abort && phase_q != DN_C) begin
            // Run down from wherever the bar is; level is left untouched.
            phase_d = DN_C;
            presc_d = '0;
        end else begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                level_d = step_lvl;
                // Kickback wins over the normal end-of-phase advance.
                if (up_kickable && flick && kick_lvl) begin
                    phase_d = (phase_q == UP_B) ? DN_A : DN_B;
                end else if (step_lvl == target) begin
                    case (phase_q)
                        UP_A:    phase_d = DN_A;
                        DN_A:    phase_d = UP_B;
                        UP_B:    phase_d = DN_B;
                        DN_B:    phase_d = UP_C;
                        UP_C:    phase_d = DN_C;
                        DN_C:    phase_d = (flick || AUTO_REPEAT != 0) ? UP_A : IDLE;
                        default: phase_d = IDLE;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= IDLE;
            level_q <= '0;
            presc_q <= '0;
        end else begin
            phase_q <= phase_d;
            level_q <= level_d;
            presc_q <= presc_d;
        end
    end

    for (genvar i = 0; i < N_LAMP; i++) begin : g_lamp
        assign lamp[i] = (level_q > LW'(i));
    end

    assign busy  = (phase_q != IDLE);
    assign phase = phase_q;

endmodule
